regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (write-enable, 5-bit address, data; captured on the falling clock edge) among NREQ independent writeback requesters, e.g. ALU, load unit and multiplier.
- Round-robin arbitration; one write issued per cycle at most.
- Outputs are registered on the rising edge, so the register file captures them at the following falling edge of the same cycle.
- Sits between the execute/writeback stages and the register file.

Parameters:
- WIDTH, 32, data width of one register.
- NREQ, 3, number of requesters (2..8).
- AW, 5, register address width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester write request, level, held until granted.
- req_addr  input  NREQ*AW  packed destination addresses; requester i occupies bits [i*AW +: AW].
- req_data  input  NREQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
- stall  input  1  when high, no new grant is issued.
- gnt  output  NREQ  one-hot, one-cycle grant acknowledge (registered).
- wr_en  output  1  register file write enable (registered).
- wr_addr  output  AW  register file write address (registered).
- wr_data  output  WIDTH  register file write data (registered).
- write_count  output  16  number of committed writes, wraps.
- drop_count  output  8  number of writes to address 0 that were dropped, saturates at 255.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset, asserted at any time including mid-grant:
  - Immediately clears gnt, wr_en, wr_addr, wr_data, write_count, drop_count.
  - Sets rr_ptr to 0.
  - Nothing is retained; requesters re-present their requests after reset.
- Eligibility at each rising edge: requester i is eligible if req[i]=1 and gnt[i]=0 at that edge.
  - This masks the requester in the cycle after its grant, so a held req is never double-written.
  - Sustained rate is therefore at most one grant per requester every 2 cycles.
- Selection: the first eligible index starting at rr_ptr and ascending modulo NREQ.
- Grant, when stall=0 and a winner w exists, at the rising edge:
  - gnt <= one-hot(w).
  - wr_addr <= req_addr[w]; wr_data <= req_data[w].
  - wr_en <= (req_addr[w] != 0).
  - rr_ptr <= (w+1) mod NREQ.
  - Latency: req sampled at edge k produces gnt/wr_en high for cycle k..k+1; the register file commits at the falling edge inside that cycle.
- No grant (stall=1 or no eligible requester):
  - gnt <= 0, wr_en <= 0; wr_addr and wr_data hold their previous values; rr_ptr holds.
  - stall never cancels a grant already issued.
- Address 0:
  - The requester is still granted (gnt pulses) and rr_ptr advances.
  - wr_en stays 0; drop_count increments, saturating at 255.
- write_count: increments by 1 at every edge where wr_en <= 1 is loaded; wraps at 16'hFFFF -> 0.
- Requester obligations:
  - Hold req, addr and data stable until gnt[i] is seen high.
  - Then either drop req or present the next payload by the next rising edge.
  - Deasserting req before the grant withdraws the request and is legal.
- Same-address collisions between requesters: no merging. Grants serialize in round-robin order, so the later grant's data is final.
- Forbidden states: gnt is never multi-hot; wr_en=1 implies exactly one gnt bit set.

Test Plan:
- Reset, then a single request: req=3'b001, addr=5, data=32'hDEADBEEF for 1 cycle -> next cycle gnt=001, wr_en=1, wr_addr=5, wr_data=DEADBEEF; register file reg5 = DEADBEEF after the falling edge; write_count=1.
- All three requesters held, with addrs 1/2/3 and payloads updated after each own grant, for 12 cycles -> grant order 0,1,2,0,1,2 with no requester granted on consecutive cycles; 6 writes; write_count=6; gnt always one-hot.
- Write to address 0: req[1]=1, addr=0, data=32'h55 -> gnt=010, wr_en=0, drop_count=1, reg0 unchanged. Repeat 300 times -> drop_count=255.
- Stall: req=3'b110 with stall=1 for 4 cycles -> gnt=0, wr_en=0 throughout. Release stall -> requester 1 granted first (rr_ptr=0 skips idle 0), then requester 2.
- Asynchronous reset asserted mid-cycle while gnt=100, wr_en=1 -> outputs clear without a clock edge; write_count=0; after release, the first grant goes to the lowest eligible index.
- Counter wrap: preload the model to write_count=16'hFFFF via 65535 writes, then one more write -> write_count=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port
// among NREQ writeback requesters; outputs registered on rising edge.
module regfile_write_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 3,
  parameter int AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  stall,
  output logic [NREQ-1:0]       gnt,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic [15:0]           write_count,
  output logic [7:0]            drop_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [PW-1:0]    rrPtr;
  logic [PW-1:0]    win;
  logic [PW-1:0]    nextPtr;
  logic             found;
  logic [NREQ-1:0]  elig;
  logic [AW-1:0]    winAddr;
  logic [WIDTH-1:0] winData;
  logic             addrZero;
  int               idx;

  // A requester granted last cycle is masked so a held req is not rewritten.
  assign elig = req & ~gnt;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rrPtr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign winAddr  = req_addr[int'(win)*AW +: AW];
  assign winData  = req_data[int'(win)*WIDTH +: WIDTH];
  assign addrZero = (winAddr == '0);
  assign nextPtr  = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      write_count <= '0;
      drop_count  <= '0;
      rrPtr       <= '0;
    end else if (!stall && found) begin
      gnt     <= ONE << win;
      wr_addr <= winAddr;
      wr_data <= winData;
      wr_en   <= !addrZero;
      rrPtr   <= nextPtr;
      if (addrZero) begin
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end else begin
        write_count <= write_count + 16'd1;
      end
    end else begin
      gnt   <= '0;
      wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants, a negedge
// monitor pops and compares whenever the arbiter issues a grant.
module tb_regfile_write_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 3;
  localparam int AW    = 5;

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic             wrEn;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*AW-1:0]    req_addr = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic                  stall = 1'b0;
  logic [NREQ-1:0]       gnt;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [15:0]           write_count;
  logic [7:0]            drop_count;

  exp_t             expQ[$];
  logic [WIDTH-1:0] rf[32];
  logic [NREQ-1:0]  prevGnt = '0;
  int               checks = 0;
  int               errors = 0;

  regfile_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .req_data(req_data), .stall(stall), .gnt(gnt), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .write_count(write_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int w, input logic en,
                      input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    exp_t e;
    e.gnt  = NREQ'(1) << w;
    e.wrEn = en;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic doReset();
    req   = '0;
    stall = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_wcnt", 64'(write_count), 0);
  endtask

  task automatic waitGnt(input int i);
    bit seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      cyc();
      if (gnt[i]) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL grant_timeout: req %0d got none expected gnt", i);
    end
  endtask

  function automatic logic [WIDTH-1:0] dat(input int i, input int v);
    return 32'h1000_0000 * (i + 1) + v;
  endfunction

  always @(negedge clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("onehot", 64'($onehot0(gnt)), 1);
      if (wr_en) chk("wren_gnt", 64'($onehot(gnt)), 1);
      if (gnt != '0 || wr_en) begin
        chk("no_repeat", 64'(gnt & prevGnt), 0);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got gnt=%b expected none", gnt);
        end else begin
          e = expQ.pop_front();
          chk("gnt", 64'(gnt), 64'(e.gnt));
          chk("wr_en", 64'(wr_en), 64'(e.wrEn));
          chk("wr_addr", 64'(wr_addr), 64'(e.addr));
          chk("wr_data", 64'(wr_data), 64'(e.data));
        end
      end
      prevGnt <= gnt;
    end else begin
      prevGnt <= '0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt[NREQ];
    for (int r = 0; r < 32; r++) rf[r] = '0;
    #1;
    cyc();
    chk("rst_wren", 64'(wr_en), 0);
    chk("rst_drop", 64'(drop_count), 0);
    doReset();

    // single write
    req = 3'b001;
    req_addr[0 +: AW] = 5'd5;
    req_data[0 +: WIDTH] = 32'hDEADBEEF;
    push(0, 1'b1, 5'd5, 32'hDEADBEEF);
    cyc();
    req = '0;
    chk("single_wcnt", 64'(write_count), 1);
    @(negedge clk);
    #1;
    chk("rf5", 64'(rf[5]), 64'h0000_0000_DEADBEEF);
    cyc();

    // all three held, round robin
    doReset();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = AW'(i + 1);
      req_data[i*WIDTH +: WIDTH] = dat(i, 0);
      cnt[i] = 0;
    end
    for (int g = 0; g < 6; g++) push(g % 3, 1'b1, AW'(g % 3 + 1), dat(g % 3, g / 3));
    req = 3'b111;
    for (int c = 0; c < 12 && req != '0; c++) begin
      cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          cnt[i]++;
          if (cnt[i] == 2) req[i] = 1'b0;
          else req_data[i*WIDTH +: WIDTH] = dat(i, 1);
        end
      end
    end
    cyc();
    chk("rr_wcnt", 64'(write_count), 6);

    // address zero drops
    req_addr[AW +: AW] = '0;
    req_data[WIDTH +: WIDTH] = 32'h55;
    req = 3'b010;
    for (int n = 0; n < 300; n++) begin
      push(1, 1'b0, '0, 32'h55);
      waitGnt(1);
      if (n == 0) chk("drop1", 64'(drop_count), 1);
    end
    req = '0;
    cyc();
    chk("drop_sat", 64'(drop_count), 255);
    chk("drop_wcnt", 64'(write_count), 6);
    chk("rf0", 64'(rf[0]), 0);

    // stall
    doReset();
    req_addr[AW +: AW] = 5'd6;
    req_addr[2*AW +: AW] = 5'd7;
    req_data[WIDTH +: WIDTH] = 32'h6666;
    req_data[2*WIDTH +: WIDTH] = 32'h7777;
    req = 3'b110;
    stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_gnt", 64'(gnt), 0);
      chk("stall_wren", 64'(wr_en), 0);
    end
    cyc();
    push(1, 1'b1, 5'd6, 32'h6666);
    push(2, 1'b1, 5'd7, 32'h7777);
    stall = 1'b0;
    for (int c = 0; c < 6 && req != '0; c++) begin
      cyc();
      req = req & ~gnt;
    end
    chk("stall_left", 64'(req), 0);
    cyc();

    // async reset mid grant
    doReset();
    req_addr[2*AW +: AW] = 5'd9;
    req_data[2*WIDTH +: WIDTH] = 32'hA5A5;
    req = 3'b100;
    cyc();
    chk("pre_rst_gnt", 64'(gnt), 64'b100);
    chk("pre_rst_wren", 64'(wr_en), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 64'(gnt), 0);
    chk("arst_wren", 64'(wr_en), 0);
    chk("arst_addr", 64'(wr_addr), 0);
    chk("arst_data", 64'(wr_data), 0);
    chk("arst_wcnt", 64'(write_count), 0);
    rst_n = 1'b1;
    req_addr[AW +: AW] = 5'd10;
    req_addr[2*AW +: AW] = 5'd11;
    req_data[WIDTH +: WIDTH] = 32'hB0;
    req_data[2*WIDTH +: WIDTH] = 32'hB1;
    req = 3'b110;
    push(1, 1'b1, 5'd10, 32'hB0);
    push(2, 1'b1, 5'd11, 32'hB1);
    for (int c = 0; c < 6 && req != '0; c++) begin
      cyc();
      req = req & ~gnt;
    end
    chk("arst_left", 64'(req), 0);
    cyc();

    // write_count wrap
    doReset();
    req_addr[0 +: AW] = 5'd1;
    req_addr[AW +: AW] = 5'd2;
    req_data[0 +: WIDTH] = 32'h11;
    req_data[WIDTH +: WIDTH] = 32'h22;
    for (int g = 0; g < 65536; g++) begin
      if (g % 2 == 0) push(0, 1'b1, 5'd1, 32'h11);
      else push(1, 1'b1, 5'd2, 32'h22);
    end
    req = 3'b011;
    for (int g = 0; g < 65535; g++) cyc();
    chk("wcnt_ffff", 64'(write_count), 64'hFFFF);
    cyc();
    req = '0;
    chk("wcnt_wrap", 64'(write_count), 0);

    repeat (3) cyc();
    chk("queue_empty", 64'(expQ.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
